// File: rtl/assign_stim_gen.sv
// Clocked exhaustive sweep of the operand set (a,b,c,d) for the
// continuous-assign operator block: hold, strobe, one tail vector, done.
module assign_stim_gen #(
  parameter int D_WIDTH     = 3,
  parameter int HOLD_CYCLES = 5,
  parameter int VEC_W       = D_WIDTH + 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  output logic               a,
  output logic               b,
  output logic               c,
  output logic [D_WIDTH-1:0] d,
  output logic               valid,
  output logic               strobe,
  output logic               last,
  output logic               done,
  output logic [VEC_W-1:0]   vec_count
);

  localparam int N_W = D_WIDTH + 3;
  localparam int CW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0]    H_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [VEC_W-1:0] V_LAST = VEC_W'(2 ** N_W - 1);
  localparam logic             H_ONE  = (HOLD_CYCLES == 1);

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("assign_stim_gen: HOLD_CYCLES must be >= 1");
  end
  if (VEC_W < N_W + 1) begin : g_bad_vecw
    $error("assign_stim_gen: VEC_W too narrow for the tail index");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_TAIL,
    S_DONE
  } state_t;

  state_t             r_state, w_state;
  logic [N_W-1:0]     r_vec, w_vec;
  logic [CW-1:0]      r_cnt, w_cnt;
  logic [VEC_W-1:0]   r_vc, w_vc;
  logic               r_seen, w_seen;
  logic               r_valid, w_valid;
  logic               r_strobe, w_strobe;
  logic               r_last, w_last;
  logic               r_done, w_done;
  logic               w_hold_end;

  // r_seen marks that this vector's strobe has been shown, so a pause
  // landing on the strobe cycle never repeats or skips it
  assign w_hold_end = (r_cnt == H_LAST) && r_seen;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_vec    <= '0;
      r_cnt    <= '0;
      r_vc     <= '0;
      r_seen   <= 1'b0;
      r_valid  <= 1'b0;
      r_strobe <= 1'b0;
      r_last   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_vec    <= w_vec;
      r_cnt    <= w_cnt;
      r_vc     <= w_vc;
      r_seen   <= w_seen;
      r_valid  <= w_valid;
      r_strobe <= w_strobe;
      r_last   <= w_last;
      r_done   <= w_done;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_vec    = r_vec;
    w_cnt    = r_cnt;
    w_vc     = r_vc;
    w_seen   = r_seen;
    w_valid  = r_valid;
    w_strobe = 1'b0;
    w_last   = r_last;
    w_done   = r_done;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state  = S_RUN;
          w_vec    = '0;
          w_cnt    = '0;
          w_vc     = '0;
          w_valid  = 1'b1;
          w_last   = 1'b0;
          w_done   = 1'b0;
          w_strobe = H_ONE && !pause;
          w_seen   = H_ONE && !pause;
        end
      end
      S_RUN, S_TAIL: begin
        if (!pause) begin
          if (w_hold_end) begin
            w_cnt    = '0;
            w_strobe = H_ONE;
            w_seen   = H_ONE;
            if (r_state == S_TAIL) begin
              w_state  = S_DONE;
              w_valid  = 1'b0;
              w_last   = 1'b0;
              w_done   = 1'b1;
              w_strobe = 1'b0;
              w_seen   = 1'b0;
            end else if (r_vc == V_LAST) begin
              w_state = S_TAIL;
              w_vec   = {2'b00, r_vec[N_W-3:0]};
              w_last  = 1'b1;
              w_vc    = r_vc + 1'b1;
            end else begin
              w_vec = r_vec + 1'b1;
              w_vc  = r_vc + 1'b1;
            end
          end else if (r_cnt == H_LAST) begin
            w_strobe = 1'b1;
            w_seen   = 1'b1;
          end else begin
            w_cnt    = r_cnt + 1'b1;
            w_strobe = (w_cnt == H_LAST);
            w_seen   = (w_cnt == H_LAST);
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign a         = r_vec[N_W-1];
  assign b         = r_vec[N_W-2];
  assign c         = r_vec[N_W-3];
  assign d         = r_vec[D_WIDTH-1:0];
  assign valid     = r_valid;
  assign strobe    = r_strobe;
  assign last      = r_last;
  assign done      = r_done;
  assign vec_count = r_vc;

endmodule

// File: doc/assign_stim_gen.md
Name: assign_stim_gen

Overview:
- Synthesizable stimulus sequencer that drives the operand set a, b, c, d of the continuous-assign operator diagnostic.
- Replaces the testbench's nested for-loops with clocked RTL so the operator block can be exercised by a clocked harness.
- Walks every combination exhaustively in a fixed order, holds each vector a programmable number of cycles, then applies one tail vector and signals done.
- Sits directly upstream of the operator block; a, b, c, d connect straight to its inputs.

Parameters:
- D_WIDTH, 3: width of d. d sweeps 0 .. 2^D_WIDTH-1.
- HOLD_CYCLES, 5: clock cycles each vector is held. Legal range >=1; any other value is a config error (simulation $error at time 0).
- VEC_W, D_WIDTH+4: width of vec_count. Must hold 2^(D_WIDTH+3)+1.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  begin sequence (level-sampled)
- pause  input  1  freeze sequence while high
- a  output  1  operand a (slowest-varying)
- b  output  1  operand b
- c  output  1  operand c
- d  output  D_WIDTH  operand d (fastest-varying)
- valid  output  1  high while a vector is being presented
- strobe  output  1  one-cycle pulse on the last hold cycle of each vector (sampling point for downstream)
- last  output  1  high while the tail vector is presented
- done  output  1  sequence complete
- vec_count  output  VEC_W  index of the current vector (0-based)

Behaviour:
- Reset (asynchronous, any state): state=IDLE. a=b=c=0, d=0, valid=strobe=last=done=0, vec_count=0, hold counter=0. Reset asserted mid-sequence aborts immediately; no partial vector completes.
- States: IDLE, RUN, TAIL, DONE.
- IDLE -> RUN when start=1 at a clock edge. Vector 0 (a=b=c=0, d=0) and valid=1 appear on that edge (latency 1 cycle from start).
- Sequence order in RUN:
  - d increments fastest 0 .. 2^D_WIDTH-1.
  - On d wrap, c toggles. On c wrap 1->0, b toggles. On b wrap, a toggles.
  - Total of 2^(D_WIDTH+3) vectors (64 at default). vec_count increments by 1 per vector.
- Hold counter:
  - Counts 0 .. HOLD_CYCLES-1 per vector.
  - strobe=1 exactly when count=HOLD_CYCLES-1 and pause=0.
  - The vector advances on the edge following that cycle.
  - With HOLD_CYCLES=1, strobe is high every unpaused cycle and the vector changes every cycle.
- RUN -> TAIL after the strobe of the final vector (a=b=c=1, d=all-ones):
  - a=0, b=0; c and d retain their last values (c=1, d=all-ones).
  - last=1, valid=1, vec_count=2^(D_WIDTH+3).
  - The tail is held HOLD_CYCLES cycles with a normal strobe.
- TAIL -> DONE after the tail strobe:
  - valid=0, last=0, done=1.
  - a, b, c, d hold the tail values.
  - vec_count holds.
- DONE -> RUN when start=1: restarts from vector 0 with vec_count=0 and done cleared on the same edge.
- start in RUN or TAIL is ignored.
- pause=1 in RUN or TAIL:
  - Hold counter, vector and vec_count freeze; strobe is forced 0; valid stays 1.
  - The cycle after pause drops, counting resumes from the frozen count.
- pause in IDLE or DONE has no effect.
- Simultaneous events:
  - start=1 and pause=1 in IDLE: transition to RUN, hold counter frozen at 0 until pause drops.
  - Simultaneous reset wins over all inputs.
- All outputs are registered; there are no combinational paths from input to output.

Test Plan:
- Reset release, start pulse at cycle 3 -> cycle 4: valid=1, a=b=c=0, d=0, vec_count=0. First strobe at cycle 8; d=1 at cycle 9.
- Default params, run to completion -> 64 strobes with (a,b,c,d) in order 0/0/0/0 … 1/1/1/7. Tail vector a=0,b=0,c=1,d=7 with last=1 and vec_count=64. done=1 exactly 65*5 cycles after the first valid.
- pause high for 7 cycles at hold count 2 of vector 10 -> vector 10 held 12 cycles total, no strobe during pause, vec_count stays 10.
- HOLD_CYCLES=1 -> strobe continuously high from the first valid; d changes every cycle; done after 65 vectors.
- Async reset asserted mid-cycle during vector 37 -> outputs zero immediately (before the next edge), state IDLE. A new start restarts at vector 0.
- start held high in DONE -> restart on the next edge with done=0, vec_count=0. start toggled during RUN -> no effect on sequence or count.
